// File: rtl/vpg_param.sv
// Parametrised raster timing and test-pattern generator for the HDMI pixel port; VPG_BORDER_EN adds a forced white border.
// Latency: all outputs registered one clock after the h/v counters. There is no backpressure: the raster free-runs while enable is high.
module vpg_param #(
    parameter int H_DISP   = 1920,
    parameter int H_FP     = 88,
    parameter int H_SYNC   = 44,
    parameter int H_BP     = 148,
    parameter int V_DISP   = 1080,
    parameter int V_FP     = 4,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 36,
    parameter bit HS_POL   = 1'b1,
    parameter bit VS_POL   = 1'b1,
    parameter int COLOR_W  = 8,
    parameter int CNT_W    = 12,
    parameter int BOX_SIZE = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [2:0]           pattern_sel,
    input  logic [3*COLOR_W-1:0] solid_rgb,
    input  logic                 pattern_load,
    output logic [2:0]           active_pattern,
    output logic                 frame_start,
    output logic                 vpg_de,
    output logic                 vpg_hs,
    output logic                 vpg_vs,
    output logic [COLOR_W-1:0]   vpg_r,
    output logic [COLOR_W-1:0]   vpg_g,
    output logic [COLOR_W-1:0]   vpg_b
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_DISP / 8;

    localparam logic [CNT_W-1:0] H_LAST    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_DISP);
    localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_DISP);
    localparam logic [CNT_W-1:0] HS_START  = CNT_W'(H_DISP + H_FP);
    localparam logic [CNT_W-1:0] HS_END    = CNT_W'(H_DISP + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START  = CNT_W'(V_DISP + V_FP);
    localparam logic [CNT_W-1:0] VS_END    = CNT_W'(V_DISP + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BOX_C     = CNT_W'(BOX_SIZE);
    localparam logic [CNT_W-1:0] BOX_Y0    = CNT_W'((V_DISP - BOX_SIZE) / 2);
    localparam logic [CNT_W-1:0] BOX_X_MAX = CNT_W'(H_DISP - BOX_SIZE);
    localparam logic [3*COLOR_W-1:0] WHITE = '1;

    logic [CNT_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, box_x_q, box_x_d;
    logic [2:0]           pend_sel_q, pend_sel_d, act_sel_q, act_sel_d;
    logic [3*COLOR_W-1:0] pend_rgb_q, pend_rgb_d, act_rgb_q, act_rgb_d;
    logic                 de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    logic                 boundary, de_raw, hs_raw, vs_raw, in_box;
    logic [2:0]           bar;
    logic [3*COLOR_W-1:0] pix;

    always_comb begin
        h_cnt_d    = h_cnt_q;
        v_cnt_d    = v_cnt_q;
        box_x_d    = box_x_q;
        pend_sel_d = pend_sel_q;
        pend_rgb_d = pend_rgb_q;
        act_sel_d  = act_sel_q;
        act_rgb_d  = act_rgb_q;
        bar        = 3'd0;
        pix        = '0;

        boundary = enable && (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
        de_raw   = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs_raw   = (h_cnt_q >= HS_START) && (h_cnt_q < HS_END);
        vs_raw   = (v_cnt_q >= VS_START) && (v_cnt_q < VS_END);
        in_box   = (h_cnt_q >= box_x_q) && (h_cnt_q < box_x_q + BOX_C) &&
                   (v_cnt_q >= BOX_Y0) && (v_cnt_q < BOX_Y0 + BOX_C);

        if (!enable) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
        end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end

        if (pattern_load) begin
            pend_sel_d = pattern_sel;
            pend_rgb_d = solid_rgb;
        end
        // Pending -> active swap on the last cycle so a frame never mixes patterns.
        if (boundary) begin
            act_sel_d = pend_sel_q;
            act_rgb_d = pend_rgb_q;
        end

        if (!enable) begin
            box_x_d = '0;
        end else if (boundary) begin
            box_x_d = (box_x_q == BOX_X_MAX) ? '0 : box_x_q + CNT_W'(1);
        end

        // Bar index by threshold compare; the final bar keeps any remainder.
        for (int i = 1; i < 8; i++) begin
            if (h_cnt_q >= CNT_W'(i * BAR_W)) bar = 3'(i);
        end

        case (act_sel_q)
            3'd0:    pix = act_rgb_q;
            3'd1:    pix = {{COLOR_W{~bar[1]}}, {COLOR_W{~bar[2]}}, {COLOR_W{~bar[0]}}};
            3'd2:    pix = {3{h_cnt_q[COLOR_W-1:0]}};
            3'd3:    pix = ((h_cnt_q[4:0] == 5'd0) || (v_cnt_q[4:0] == 5'd0)) ? WHITE : '0;
            3'd4:    pix = in_box ? WHITE : '0;
            default: pix = '0;
        endcase

`ifdef VPG_BORDER_EN
        if ((h_cnt_q == '0) || (h_cnt_q == H_ACT - CNT_W'(1)) ||
            (v_cnt_q == '0) || (v_cnt_q == V_ACT - CNT_W'(1))) begin
            pix = WHITE;
        end
`endif

        de_d  = enable && de_raw;
        hs_d  = (enable && hs_raw) ? HS_POL : ~HS_POL;
        vs_d  = (enable && vs_raw) ? VS_POL : ~VS_POL;
        fs_d  = enable && (h_cnt_q == '0) && (v_cnt_q == '0);
        rgb_d = de_d ? pix : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            box_x_q    <= '0;
            pend_sel_q <= '0;
            pend_rgb_q <= '0;
            act_sel_q  <= '0;
            act_rgb_q  <= '0;
            de_q       <= 1'b0;
            hs_q       <= ~HS_POL;
            vs_q       <= ~VS_POL;
            fs_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            box_x_q    <= box_x_d;
            pend_sel_q <= pend_sel_d;
            pend_rgb_q <= pend_rgb_d;
            act_sel_q  <= act_sel_d;
            act_rgb_q  <= act_rgb_d;
            de_q       <= de_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
            rgb_q      <= rgb_d;
        end
    end

    assign active_pattern = act_sel_q;
    assign frame_start    = fs_q;
    assign vpg_de         = de_q;
    assign vpg_hs         = hs_q;
    assign vpg_vs         = vs_q;
    assign vpg_r          = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign vpg_g          = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign vpg_b          = rgb_q[COLOR_W-1:0];
endmodule

// File: tb/tb_vpg_param.sv
// Directed bench for vpg_param on a 22x11 raster (16x8 active); outputs sampled on the falling edge.
module tb_vpg_param;
    localparam int HT = 22;
    localparam int FT = 242;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [2:0]  pattern_sel = 3'd0;
    logic [23:0] solid_rgb = 24'h0;
    logic        pattern_load = 1'b0;
    logic [2:0]  active_pattern;
    logic        frame_start, vpg_de, vpg_hs, vpg_vs;
    logic [7:0]  vpg_r, vpg_g, vpg_b;

    int total = 0;
    int bad = 0;
    int kpos = 0;
    int cur = 0;

    always #5 clk = ~clk;

    vpg_param #(
        .H_DISP(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_DISP(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(8), .CNT_W(12), .BOX_SIZE(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb), .pattern_load(pattern_load),
        .active_pattern(active_pattern), .frame_start(frame_start),
        .vpg_de(vpg_de), .vpg_hs(vpg_hs), .vpg_vs(vpg_vs),
        .vpg_r(vpg_r), .vpg_g(vpg_g), .vpg_b(vpg_b)
    );

    // Expected active pixel colour, including the optional white border.
    function automatic logic [23:0] px(input int x, input int y, input logic [23:0] v);
`ifdef VPG_BORDER_EN
        if (x == 0 || x == 15 || y == 0 || y == 7) return 24'hFFFFFF;
`endif
        return v;
    endfunction

    task automatic tick();
        @(negedge clk);
        cur = kpos;
        kpos++;
    endtask

    task automatic goto(input int p);
        while (kpos <= p) tick();
    endtask

    task automatic goto_px(input int f, input int x, input int y);
        goto(f * FT + y * HT + x);
    endtask

    // Load is seen by the DUT on the edge where the counters sit one position past cur.
    task automatic load(input logic [2:0] sel, input logic [23:0] rgb);
        pattern_sel  = sel;
        solid_rgb    = rgb;
        pattern_load = 1'b1;
        tick();
        pattern_load = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (3) tick();
        total++; if (vpg_de !== 1'b0) begin bad++; $display("FAIL reset_de got %b want 0", vpg_de); end
        total++; if (vpg_hs !== 1'b0) begin bad++; $display("FAIL reset_hs got %b want 0", vpg_hs); end
        total++; if (vpg_vs !== 1'b0) begin bad++; $display("FAIL reset_vs got %b want 0", vpg_vs); end
        total++; if (frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got %b want 0", frame_start); end
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'h0) begin bad++; $display("FAIL reset_rgb got %h want 000000", {vpg_r, vpg_g, vpg_b}); end
        total++; if (active_pattern !== 3'd0) begin bad++; $display("FAIL reset_pat got %0d want 0", active_pattern); end
    endtask

    task automatic test_timing();
        int h, v, des, fss;
        logic e_de, e_hs, e_vs, e_fs;
        logic [23:0] e_rgb;
        des = 0;
        fss = 0;
        reset = 1'b0;
        enable = 1'b1;
        kpos = 0;
        for (int i = 0; i < 2 * FT; i++) begin
            tick();
            h = cur % HT;
            v = (cur / HT) % 11;
            e_de = (h < 16) && (v < 8);
            e_hs = (h == 18) || (h == 19);
            e_vs = (v == 9);
            e_fs = (cur % FT) == 0;
            e_rgb = e_de ? px(h, v, 24'h0) : 24'h0;
            if (vpg_de === 1'b1) des++;
            if (frame_start === 1'b1) fss++;
            total++; if (vpg_de !== e_de) begin bad++; $display("FAIL tim_de pos=%0d got %b want %b", cur, vpg_de, e_de); end
            total++; if (vpg_hs !== e_hs) begin bad++; $display("FAIL tim_hs pos=%0d got %b want %b", cur, vpg_hs, e_hs); end
            total++; if (vpg_vs !== e_vs) begin bad++; $display("FAIL tim_vs pos=%0d got %b want %b", cur, vpg_vs, e_vs); end
            total++; if (frame_start !== e_fs) begin bad++; $display("FAIL tim_fs pos=%0d got %b want %b", cur, frame_start, e_fs); end
            total++; if ({vpg_r, vpg_g, vpg_b} !== e_rgb) begin bad++; $display("FAIL tim_rgb pos=%0d got %h want %h", cur, {vpg_r, vpg_g, vpg_b}, e_rgb); end
        end
        total++; if (des != 256) begin bad++; $display("FAIL tim_de_count got %0d want 256", des); end
        total++; if (fss != 2) begin bad++; $display("FAIL tim_fs_count got %0d want 2", fss); end
    endtask

    task automatic test_bars();
        int xs[7] = '{0, 1, 2, 3, 4, 14, 15};
        logic [23:0] ex[7] = '{24'hFFFFFF, 24'hFFFFFF, 24'hFFFF00, 24'hFFFF00, 24'h00FFFF, 24'h000000, 24'h000000};
        goto(2 * FT + 50);
        load(3'd1, 24'h0);
        goto(2 * FT + 240);
        total++; if (active_pattern !== 3'd0) begin bad++; $display("FAIL bars_pat_before got %0d want 0", active_pattern); end
        for (int i = 0; i < 7; i++) begin
            goto_px(3, xs[i], 3);
            total++; if ({vpg_r, vpg_g, vpg_b} !== px(xs[i], 3, ex[i])) begin bad++; $display("FAIL bars_x%0d got %h want %h", xs[i], {vpg_r, vpg_g, vpg_b}, px(xs[i], 3, ex[i])); end
        end
        total++; if (active_pattern !== 3'd1) begin bad++; $display("FAIL bars_pat got %0d want 1", active_pattern); end
    endtask

    task automatic test_pattern_switch();
        goto(3 * FT + 60);
        load(3'd2, 24'h0);
        goto_px(4, 7, 1);
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(7, 1, 24'h070707)) begin bad++; $display("FAIL ramp_x7 got %h want %h", {vpg_r, vpg_g, vpg_b}, px(7, 1, 24'h070707)); end
        goto(4 * FT + 100);
        load(3'd0, 24'h123456);
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(13, 4, 24'h0D0D0D)) begin bad++; $display("FAIL ramp_after_load got %h want %h", {vpg_r, vpg_g, vpg_b}, px(13, 4, 24'h0D0D0D)); end
        goto_px(4, 9, 6);
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(9, 6, 24'h090909)) begin bad++; $display("FAIL ramp_hold got %h want %h", {vpg_r, vpg_g, vpg_b}, px(9, 6, 24'h090909)); end
        goto(4 * FT + 240);
        total++; if (active_pattern !== 3'd2) begin bad++; $display("FAIL switch_pat_before got %0d want 2", active_pattern); end
        goto_px(5, 0, 0);
        total++; if (active_pattern !== 3'd0) begin bad++; $display("FAIL switch_pat got %0d want 0", active_pattern); end
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(0, 0, 24'h123456)) begin bad++; $display("FAIL solid_00 got %h want %h", {vpg_r, vpg_g, vpg_b}, px(0, 0, 24'h123456)); end
        goto_px(5, 8, 3);
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'h123456) begin bad++; $display("FAIL solid_83 got %h want 123456", {vpg_r, vpg_g, vpg_b}); end
        goto_px(5, 15, 7);
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(15, 7, 24'h123456)) begin bad++; $display("FAIL solid_last got %h want %h", {vpg_r, vpg_g, vpg_b}, px(15, 7, 24'h123456)); end
    endtask

    task automatic test_multi_load();
        goto(5 * FT + 180);
        load(3'd3, 24'h123456);
        goto(5 * FT + 200);
        load(3'd1, 24'h123456);
        goto(5 * FT + 240);
        load(3'd4, 24'h123456);
        total++; if (active_pattern !== 3'd1) begin bad++; $display("FAIL multi_pat got %0d want 1", active_pattern); end
        goto_px(6, 2, 0);
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(2, 0, 24'hFFFF00)) begin bad++; $display("FAIL multi_x2 got %h want %h", {vpg_r, vpg_g, vpg_b}, px(2, 0, 24'hFFFF00)); end
        goto_px(6, 6, 5);
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'h00FF00) begin bad++; $display("FAIL multi_x6 got %h want 00ff00", {vpg_r, vpg_g, vpg_b}); end
        goto(6 * FT + 240);
        total++; if (active_pattern !== 3'd1) begin bad++; $display("FAIL edge_load_early got %0d want 1", active_pattern); end
        tick();
        total++; if (active_pattern !== 3'd4) begin bad++; $display("FAIL edge_load_pat got %0d want 4", active_pattern); end
    endtask

    task automatic test_moving_box();
        int bx;
        for (int f = 7; f <= 13; f++) begin
            bx = f % 13;
            goto_px(f, bx, 1);
            total++; if ({vpg_r, vpg_g, vpg_b} !== px(bx, 1, 24'h0)) begin bad++; $display("FAIL box_above f=%0d got %h want %h", f, {vpg_r, vpg_g, vpg_b}, px(bx, 1, 24'h0)); end
            if (bx > 0) begin
                goto_px(f, bx - 1, 2);
                total++; if ({vpg_r, vpg_g, vpg_b} !== px(bx - 1, 2, 24'h0)) begin bad++; $display("FAIL box_left f=%0d got %h want %h", f, {vpg_r, vpg_g, vpg_b}, px(bx - 1, 2, 24'h0)); end
            end
            goto_px(f, bx, 2);
            total++; if ({vpg_r, vpg_g, vpg_b} !== 24'hFFFFFF) begin bad++; $display("FAIL box_tl f=%0d got %h want ffffff", f, {vpg_r, vpg_g, vpg_b}); end
            if (bx + 4 <= 15) begin
                goto_px(f, bx + 4, 2);
                total++; if ({vpg_r, vpg_g, vpg_b} !== px(bx + 4, 2, 24'h0)) begin bad++; $display("FAIL box_right f=%0d got %h want %h", f, {vpg_r, vpg_g, vpg_b}, px(bx + 4, 2, 24'h0)); end
            end
            goto_px(f, bx + 3, 5);
            total++; if ({vpg_r, vpg_g, vpg_b} !== 24'hFFFFFF) begin bad++; $display("FAIL box_br f=%0d got %h want ffffff", f, {vpg_r, vpg_g, vpg_b}); end
            goto_px(f, bx, 6);
            total++; if ({vpg_r, vpg_g, vpg_b} !== px(bx, 6, 24'h0)) begin bad++; $display("FAIL box_below f=%0d got %h want %h", f, {vpg_r, vpg_g, vpg_b}, px(bx, 6, 24'h0)); end
        end
    endtask

    task automatic test_enable_low();
        goto(14 * FT + HT + 18);
        total++; if (vpg_hs !== 1'b1) begin bad++; $display("FAIL en_hs_pre got %b want 1", vpg_hs); end
        enable = 1'b0;
        tick();
        total++; if (vpg_hs !== 1'b0) begin bad++; $display("FAIL en_hs got %b want 0", vpg_hs); end
        total++; if (vpg_de !== 1'b0 || vpg_vs !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL en_idle got de=%b vs=%b fs=%b want 0 0 0", vpg_de, vpg_vs, frame_start); end
        tick();
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'h0) begin bad++; $display("FAIL en_rgb got %h want 000000", {vpg_r, vpg_g, vpg_b}); end
        total++; if (active_pattern !== 3'd4) begin bad++; $display("FAIL en_pat got %0d want 4", active_pattern); end
        enable = 1'b1;
        kpos = 0;
        tick();
        total++; if (frame_start !== 1'b1 || vpg_de !== 1'b1) begin bad++; $display("FAIL en_restart got fs=%b de=%b want 1 1", frame_start, vpg_de); end
        goto_px(0, 0, 2);
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'hFFFFFF) begin bad++; $display("FAIL en_box0 got %h want ffffff", {vpg_r, vpg_g, vpg_b}); end
        goto_px(0, 4, 2);
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'h0) begin bad++; $display("FAIL en_box4 got %h want 000000", {vpg_r, vpg_g, vpg_b}); end
    endtask

    task automatic test_reset_mid();
        goto(9 * HT + 18);
        total++; if (vpg_hs !== 1'b1 || vpg_vs !== 1'b1) begin bad++; $display("FAIL rst_sync_pre got hs=%b vs=%b want 1 1", vpg_hs, vpg_vs); end
        reset = 1'b1;
        tick();
        total++; if (vpg_hs !== 1'b0 || vpg_vs !== 1'b0) begin bad++; $display("FAIL rst_sync got hs=%b vs=%b want 0 0", vpg_hs, vpg_vs); end
        total++; if (vpg_de !== 1'b0 || {vpg_r, vpg_g, vpg_b} !== 24'h0) begin bad++; $display("FAIL rst_idle got de=%b rgb=%h want 0 000000", vpg_de, {vpg_r, vpg_g, vpg_b}); end
        total++; if (active_pattern !== 3'd0) begin bad++; $display("FAIL rst_pat got %0d want 0", active_pattern); end
        reset = 1'b0;
        kpos = 0;
        goto(10);
        load(3'd4, 24'h0);
        goto_px(1, 0, 2);
        total++; if (active_pattern !== 3'd4) begin bad++; $display("FAIL rst_box_pat got %0d want 4", active_pattern); end
        total++; if ({vpg_r, vpg_g, vpg_b} !== px(0, 2, 24'h0)) begin bad++; $display("FAIL rst_box_x0 got %h want %h", {vpg_r, vpg_g, vpg_b}, px(0, 2, 24'h0)); end
        goto_px(1, 1, 2);
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'hFFFFFF) begin bad++; $display("FAIL rst_box_x1 got %h want ffffff", {vpg_r, vpg_g, vpg_b}); end
        goto_px(1, 5, 2);
        total++; if ({vpg_r, vpg_g, vpg_b} !== 24'h0) begin bad++; $display("FAIL rst_box_x5 got %h want 000000", {vpg_r, vpg_g, vpg_b}); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_timing();
        test_bars();
        test_pattern_switch();
        test_multi_load();
        test_moving_box();
        test_enable_low();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/vpg_param.md
Name: vpg_param

Overview:
- Parametrised successor to the fixed 1080p pattern generator.
- Merges the timing generator and pattern generator into one block. All raster geometry, sync polarity and colour depth are set by parameters.
- Adds run-time pattern selection that takes effect only at frame boundaries, a moving-box pattern driven by a frame counter, and a frame-start strobe.
- Drives the HDMI transmitter pixel interface directly.

Parameters:
- H_DISP, 1920, active pixels per line
- H_FP, 88, horizontal front porch, clocks
- H_SYNC, 44, horizontal sync width, clocks
- H_BP, 148, horizontal back porch, clocks
- V_DISP, 1080, active lines per frame
- V_FP, 4, vertical front porch, lines
- V_SYNC, 5, vertical sync width, lines
- V_BP, 36, vertical back porch, lines
- HS_POL, 1, hs level during sync (1 = active-high)
- VS_POL, 1, vs level during sync
- COLOR_W, 8, bits per colour channel
- CNT_W, 12, width of h/v counters; must hold H_TOTAL-1 and V_TOTAL-1
- BOX_SIZE, 64, moving-box edge length, pixels

Ports:
- clk, input, 1, pixel clock
- reset, input, 1, synchronous active-high reset
- enable, input, 1, run raster; low forces idle
- pattern_sel, input, 3, requested pattern
- solid_rgb, input, 3*COLOR_W, {r,g,b} for solid pattern
- pattern_load, input, 1, pulse: capture pattern_sel/solid_rgb
- active_pattern, output, 3, pattern currently displayed
- frame_start, output, 1, one-cycle strobe with first active pixel of frame
- vpg_de, output, 1, data enable
- vpg_hs, output, 1, horizontal sync
- vpg_vs, output, 1, vertical sync
- vpg_r, output, COLOR_W, red
- vpg_g, output, COLOR_W, green
- vpg_b, output, COLOR_W, blue

Behaviour:
- Totals: H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters.
- Line order: active, front porch, sync, back porch. Frame order is the same.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on that wrap and runs 0..V_TOTAL-1, then wraps.
- de_raw = (h_cnt < H_DISP) && (v_cnt < V_DISP).
- hs active when H_DISP+H_FP <= h_cnt < H_DISP+H_FP+H_SYNC.
- vs active when V_DISP+V_FP <= v_cnt < V_DISP+V_FP+V_SYNC. vs changes together with v_cnt.
- Latency: all outputs are registered, one clock after the counters. de, hs, vs and rgb stay mutually aligned.
- Reset, and enable low:
  - counters = 0, vpg_de = 0, vpg_hs = ~HS_POL, vpg_vs = ~VS_POL, rgb = 0, frame_start = 0, frame counter = 0.
  - Reset additionally sets the pending and active pattern registers to 0, with solid colour 0.
- Enable rising: counting starts from (0,0). Pixel (0,0) appears on the outputs one clock later, together with frame_start.
- Reset mid-frame: outputs are at idle values on the next clock, with no partial sync pulse held.
- Pattern selection:
  - pattern_load copies pattern_sel and solid_rgb into pending registers.
  - If several loads occur within one frame, the last one wins.
  - Pending registers copy into the active registers only on the boundary cycle (h_cnt = H_TOTAL-1 && v_cnt = V_TOTAL-1).
  - A load on the boundary cycle itself applies at the following boundary.
  - No frame ever mixes two patterns.
- Patterns (pixel x = h_cnt, y = v_cnt; full-scale = all ones):
  - 0 solid: active solid_rgb.
  - 1 colour bars: 8 bars of width H_DISP/8, in order white, yellow, cyan, green, magenta, red, blue, black. The last bar absorbs the remainder.
  - 2 gray ramp: r = g = b = x[COLOR_W-1:0], wrapping.
  - 3 grid: white if x[4:0] == 0 or y[4:0] == 0, else black.
  - 4 moving box:
    - white box of BOX_SIZE x BOX_SIZE at column box_x, row (V_DISP-BOX_SIZE)/2; black background.
    - box_x advances by 1 at each frame boundary and wraps from H_DISP-BOX_SIZE to 0.
  - 5-7: black.
- Outside de, rgb = 0.
- active_pattern is updated at the frame boundary.

Optional Feature:
- Macro VPG_BORDER_EN.
- When defined: any active pixel with x = 0, x = H_DISP-1, y = 0 or y = V_DISP-1 is forced to full-scale white, overriding every pattern.
- When undefined: no border logic; pixels come from the pattern only.

Test Plan:
- Sim geometry H 16/2/2/2, V 8/1/1/1, HS_POL = VS_POL = 1. Enable after reset -> de high 16 clocks of every 22; hs high for clocks 18-19 of each line; vs high for exactly line 9; frame period 242 clocks; frame_start once per frame, aligned with the first de.
- Pattern 1, H_DISP = 16 -> each bar is 2 pixels wide. Pixels 0-1 = (FF,FF,FF), pixels 2-3 = (FF,FF,00), pixels 14-15 = (00,00,00).
- pattern_load with sel = 0 and solid = 0x123456, issued mid-frame while pattern 2 is active -> rest of that frame stays ramp. Next frame is all 12/34/56; active_pattern changes to 0 at the boundary.
- Two loads in one frame (sel = 3, then sel = 1), plus a load exactly on the boundary cycle -> only sel = 1 applied at the first boundary. The boundary-cycle load applies one frame later.
- Pattern 4, BOX_SIZE = 4 -> box_x = 0, 1, ..., 12, 0 on successive frames. Reset asserted mid-frame -> next clock shows de = 0, hs = vs = 0, rgb = 0, box_x = 0.
- With VPG_BORDER_EN, pattern 0 with solid = 0 -> first/last active lines and first/last active columns are FF; interior is 0.
